fp_norm_round_pipe: RTL and testbench

Pipelined normalize-and-round back end for the parametrised FP add/sub datapath. It takes the unnormalised sum/difference from the mantissa adder, which carries guard/round/sticky bits. It performs full leading-zero normalisation, including subnormal limiting, then rounds under one of four IEEE-754 modes and packs the result with exception flags. It sits between the mantissa add stage and the result register, and uses a valid/ready handshake in both directions.

---
 rtl/fp_pkg.sv | 30 +++
 rtl/fp_norm_round_pipe_lzc.sv | 22 ++
 rtl/fp_norm_round_pipe.sv | 175 +++++++++++++++++
 tb/tb_fp_norm_round_pipe.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared types and constants for the FP add/sub normalize/round back end.
package fp_pkg;

  localparam int unsigned EXP_BITS_DEF  = 8;
  localparam int unsigned MANT_BITS_DEF = 23;

  typedef enum logic [1:0] {
    RM_RNE = 2'b00,
    RM_RTZ = 2'b01,
    RM_RUP = 2'b10,
    RM_RDN = 2'b11
  } rm_e;

  typedef struct packed {
    logic overflow;
    logic underflow;
    logic inexact;
  } flags_t;

  // Exponent field value reserved for inf/NaN.
  function automatic int unsigned exp_all_ones(input int unsigned eb);
    return (1 << eb) - 1;
  endfunction

  // Exponent field of the largest finite value.
  function automatic int unsigned exp_max_finite(input int unsigned eb);
    return exp_all_ones(eb) - 1;
  endfunction

endpackage

// File: rtl/fp_norm_round_pipe_lzc.sv
// Parametrised leading-zero counter; count = W when the input is all zero.
module fp_lzc #(
  parameter int unsigned W = 26
) (
  input  logic [W-1:0]           value,
  output logic [$clog2(W+1)-1:0] count,
  output logic                   all_zero
);

  localparam int unsigned CW = $clog2(W + 1);

  // Scan upward so the highest set bit wins the last assignment.
  always_comb begin
    count = CW'(W);
    for (int unsigned i = 0; i < W; i++) begin
      if (value[i]) count = CW'(W - 1 - i);
    end
  end

  assign all_zero = ~|value;

endmodule

// File: rtl/fp_norm_round_pipe.sv
// Two-stage normalize (S1) and round/pack (S2) back end with valid/ready on both sides.
module fp_norm_round_pipe
  import fp_pkg::*;
#(
  parameter int unsigned EXP_BITS  = EXP_BITS_DEF,
  parameter int unsigned MANT_BITS = MANT_BITS_DEF,
  parameter int unsigned WIDTH     = 1 + EXP_BITS + MANT_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_sign,
  input  logic [EXP_BITS-1:0]  in_exp,
  input  logic [MANT_BITS+4:0] in_mant,
  input  logic [1:0]           in_rm,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_result,
  output logic                 out_overflow,
  output logic                 out_underflow,
  output logic                 out_inexact
);

  localparam int unsigned M  = MANT_BITS;
  localparam int unsigned EW = EXP_BITS + 1;   // headroom for +1 on carry and on round
  localparam int unsigned SW = MANT_BITS + 4;  // hidden, fraction, G, R, S
  localparam int unsigned LW = MANT_BITS + 3;  // hidden, fraction, G, R
  localparam int unsigned CW = $clog2(LW + 1);

  localparam logic [EW-1:0]       E_ONES   = EW'(exp_all_ones(EXP_BITS));
  localparam logic [EXP_BITS-1:0] F_ONES   = EXP_BITS'(exp_all_ones(EXP_BITS));
  localparam logic [EXP_BITS-1:0] F_MAXFIN = EXP_BITS'(exp_max_finite(EXP_BITS));

  if (WIDTH != 1 + EXP_BITS + MANT_BITS) begin : g_width_check
    $error("fp_norm_round_pipe: WIDTH must equal 1+EXP_BITS+MANT_BITS");
  end

  // ---------------- handshake ----------------
  logic s1_valid, s2_valid, rdy_en, s1_adv, s2_adv;

  assign s2_adv    = !s2_valid || out_ready;
  assign s1_adv    = !s1_valid || s2_adv;
  assign in_ready  = rdy_en && s1_adv;
  assign out_valid = s2_valid;

  // Hold in_ready low during reset and for the first edge after release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdy_en <= 1'b0;
    else     rdy_en <= 1'b1;
  end

  // ---------------- S1 normalize ----------------
  logic [CW-1:0] lz_count;
  logic          lz_zero;
  logic [EW-1:0] e_in, sh_lim, sh, e_norm;
  logic [SW-1:0] sig_norm;
  logic          zero_in;

  fp_lzc #(.W(LW)) u_lzc (
    .value    (in_mant[M+3:1]),
    .count    (lz_count),
    .all_zero (lz_zero)
  );

  // Carry shifts right into sticky; otherwise shift left, limited so e never drops below 1.
  always_comb begin
    e_in    = (in_exp == '0) ? EW'(1) : {1'b0, in_exp};
    sh_lim  = e_in - EW'(1);
    sh      = (EW'(lz_count) < sh_lim) ? EW'(lz_count) : sh_lim;
    zero_in = !in_mant[M+4] && lz_zero && !in_mant[0];
    if (in_mant[M+4]) begin
      sig_norm = {in_mant[M+4:2], |in_mant[1:0]};
      e_norm   = e_in + EW'(1);
    end else begin
      sig_norm = {in_mant[M+3:1] << sh, in_mant[0]};
      e_norm   = e_in - sh;
    end
  end

  logic          s1_sign, s1_zero;
  logic [EW-1:0] s1_e;
  logic [SW-1:0] s1_sig;
  rm_e           s1_rm;

  // S1 register: capture a normalised beat whenever S1 can advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_zero  <= 1'b0;
      s1_e     <= '0;
      s1_sig   <= '0;
      s1_rm    <= RM_RNE;
    end else if (s1_adv) begin
      s1_valid <= in_valid && in_ready;
      if (in_valid && in_ready) begin
        s1_sign <= in_sign;
        s1_zero <= zero_in;
        s1_e    <= e_norm;
        s1_sig  <= sig_norm;
        s1_rm   <= rm_e'(in_rm);
      end
    end
  end

  // ---------------- S2 round / pack ----------------
  logic [M:0]          mant_pre, mant_rnd;
  logic [M+1:0]        mant_sum;
  logic                g_bit, r_bit, s_bit, lsb, any_lost, inc, ovf, to_inf;
  logic [EW-1:0]       e_rnd;
  logic [EXP_BITS-1:0] exp_field;
  logic [WIDTH-1:0]    result_next;
  flags_t              flags_next, flags_q;

  // Mode-dependent increment, carry-out renormalise, then overflow/zero override.
  always_comb begin
    mant_pre = s1_sig[SW-1:3];
    g_bit    = s1_sig[2];
    r_bit    = s1_sig[1];
    s_bit    = s1_sig[0];
    lsb      = s1_sig[3];
    any_lost = g_bit || r_bit || s_bit;
    case (s1_rm)
      RM_RNE:  inc = g_bit && (r_bit || s_bit || lsb);
      RM_RTZ:  inc = 1'b0;
      RM_RUP:  inc = !s1_sign && any_lost;
      RM_RDN:  inc = s1_sign && any_lost;
      default: inc = 1'b0;
    endcase
    mant_sum = {1'b0, mant_pre} + (M+2)'(inc);
    if (mant_sum[M+1]) begin
      mant_rnd = mant_sum[M+1:1];
      e_rnd    = s1_e + EW'(1);
    end else begin
      mant_rnd = mant_sum[M:0];
      e_rnd    = s1_e;
    end
    ovf       = (e_rnd >= E_ONES);
    to_inf    = (s1_rm == RM_RNE) || (s1_rm == RM_RUP && !s1_sign) || (s1_rm == RM_RDN && s1_sign);
    exp_field = mant_rnd[M] ? e_rnd[EXP_BITS-1:0] : '0;
    flags_next = '0;
    if (s1_zero) begin
      result_next = {s1_sign, {(WIDTH-1){1'b0}}};
    end else if (ovf) begin
      flags_next.overflow = 1'b1;
      flags_next.inexact  = 1'b1;
      result_next = to_inf ? {s1_sign, F_ONES, {M{1'b0}}} : {s1_sign, F_MAXFIN, {M{1'b1}}};
    end else begin
      flags_next.inexact   = any_lost;
      flags_next.underflow = any_lost && (exp_field == '0);
      result_next = {s1_sign, exp_field, mant_rnd[M-1:0]};
    end
  end

  // S2 register: outputs only change when S2 advances, so they hold under backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid   <= 1'b0;
      out_result <= '0;
      flags_q    <= '0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_result <= result_next;
        flags_q    <= flags_next;
      end
    end
  end

  assign out_overflow  = flags_q.overflow;
  assign out_underflow = flags_q.underflow;
  assign out_inexact   = flags_q.inexact;

endmodule

// File: tb/tb_fp_norm_round_pipe.sv
// Directed bench for fp_norm_round_pipe (binary32 configuration).
module tb_fp_norm_round_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_sign = 1'b0;
  logic [7:0]  in_exp = '0;
  logic [27:0] in_mant = '0;
  logic [1:0]  in_rm = 2'b00;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_result;
  logic        out_overflow, out_underflow, out_inexact;

  int unsigned total = 0;
  int unsigned bad = 0;

  fp_norm_round_pipe #(.EXP_BITS(8), .MANT_BITS(23), .WIDTH(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_sign       (in_sign),
    .in_exp        (in_exp),
    .in_mant       (in_mant),
    .in_rm         (in_rm),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_result    (out_result),
    .out_overflow  (out_overflow),
    .out_underflow (out_underflow),
    .out_inexact   (out_inexact)
  );

  always #5 clk = ~clk;

  // Push one beat and collect it two edges later; lat_ok reports accept + exact latency.
  task automatic run_beat(input logic sg, input logic [7:0] ex, input logic [27:0] mn,
                          input logic [1:0] rm, output logic [31:0] res,
                          output logic [2:0] fl, output logic lat_ok);
    @(negedge clk);
    out_ready = 1'b1;
    in_valid = 1'b1; in_sign = sg; in_exp = ex; in_mant = mn; in_rm = rm;
    #1 lat_ok = in_ready;
    @(negedge clk);
    in_valid = 1'b0;
    lat_ok = lat_ok && !out_valid;
    @(negedge clk);
    lat_ok = lat_ok && out_valid;
    res = out_result;
    fl  = {out_overflow, out_underflow, out_inexact};
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || out_result !== 32'h0 ||
        {out_overflow, out_underflow, out_inexact} !== 3'b000) begin
      bad++;
      $display("FAIL reset_outputs got v=%b r=%h f=%b want v=0 r=00000000 f=000",
               out_valid, out_result, {out_overflow, out_underflow, out_inexact});
    end
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
    rst = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL release_in_ready got=%b want=0", in_ready); end
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL post_release_in_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_basic();
    logic        sg [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [7:0]  ex [4] = '{8'd127, 8'd127, 8'd100, 8'd0};
    logic [27:0] mn [4] = '{28'h8000000, 28'h7FFFFFC, 28'h0000000, 28'h4000000};
    logic [1:0]  rm [4] = '{2'b00, 2'b00, 2'b01, 2'b00};
    logic [31:0] er [4] = '{32'h40000000, 32'h40000000, 32'h80000000, 32'h00800000};
    logic [2:0]  ef [4] = '{3'b000, 3'b001, 3'b000, 3'b000};
    logic [31:0] res; logic [2:0] fl; logic ok;
    for (int i = 0; i < 4; i++) begin
      run_beat(sg[i], ex[i], mn[i], rm[i], res, fl, ok);
      total++;
      if (!ok) begin bad++; $display("FAIL basic[%0d] latency got=0 want=1", i); end
      total++;
      if (res !== er[i]) begin bad++; $display("FAIL basic[%0d] result got=%h want=%h", i, res, er[i]); end
      total++;
      if (fl !== ef[i]) begin bad++; $display("FAIL basic[%0d] flags got=%b want=%b", i, fl, ef[i]); end
    end
  endtask

  task automatic test_rounding();
    logic        sg [9] = '{0, 0, 0, 0, 1, 1, 0, 0, 0};
    logic [7:0]  ex [9] = '{127, 127, 127, 127, 127, 127, 127, 1, 1};
    logic [27:0] mn [9] = '{28'h400000C, 28'h4000004, 28'h4000006, 28'h4000001, 28'h4000001,
                            28'h4000001, 28'h4000004, 28'h3FFFFFC, 28'h000000A};
    logic [1:0]  rm [9] = '{2'b00, 2'b00, 2'b00, 2'b10, 2'b10, 2'b11, 2'b01, 2'b00, 2'b01};
    logic [31:0] er [9] = '{32'h3F800002, 32'h3F800000, 32'h3F800001, 32'h3F800001, 32'hBF800000,
                            32'hBF800001, 32'h3F800000, 32'h00800000, 32'h00000001};
    logic [2:0]  ef [9] = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b011};
    logic [31:0] res; logic [2:0] fl; logic ok;
    for (int i = 0; i < 9; i++) begin
      run_beat(sg[i], ex[i], mn[i], rm[i], res, fl, ok);
      total++;
      if (!ok) begin bad++; $display("FAIL round[%0d] latency got=0 want=1", i); end
      total++;
      if (res !== er[i]) begin bad++; $display("FAIL round[%0d] result got=%h want=%h", i, res, er[i]); end
      total++;
      if (fl !== ef[i]) begin bad++; $display("FAIL round[%0d] flags got=%b want=%b", i, fl, ef[i]); end
    end
  endtask

  task automatic test_overflow();
    logic        sg [6] = '{0, 0, 1, 1, 0, 0};
    logic [7:0]  ex [6] = '{254, 254, 254, 254, 254, 255};
    logic [27:0] mn [6] = '{28'h8000000, 28'h8000000, 28'h8000000, 28'h8000000, 28'h7FFFFFC, 28'h4000000};
    logic [1:0]  rm [6] = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b00, 2'b01};
    logic [31:0] er [6] = '{32'h7F800000, 32'h7F7FFFFF, 32'hFF800000, 32'hFF7FFFFF,
                            32'h7F800000, 32'h7F7FFFFF};
    logic [31:0] res; logic [2:0] fl; logic ok;
    for (int i = 0; i < 6; i++) begin
      run_beat(sg[i], ex[i], mn[i], rm[i], res, fl, ok);
      total++;
      if (!ok) begin bad++; $display("FAIL ovf[%0d] latency got=0 want=1", i); end
      total++;
      if (res !== er[i]) begin bad++; $display("FAIL ovf[%0d] result got=%h want=%h", i, res, er[i]); end
      total++;
      if (fl !== 3'b101) begin bad++; $display("FAIL ovf[%0d] flags got=%b want=101", i, fl); end
    end
  endtask

  task automatic test_cancel();
    logic [7:0]  ex [2] = '{8'd127, 8'd3};
    logic [31:0] er [2] = '{32'h3D000000, 32'h00100000};
    logic [31:0] res; logic [2:0] fl; logic ok;
    for (int i = 0; i < 2; i++) begin
      run_beat(1'b0, ex[i], 28'h0200000, 2'b00, res, fl, ok);
      total++;
      if (!ok) begin bad++; $display("FAIL cancel[%0d] latency got=0 want=1", i); end
      total++;
      if (res !== er[i]) begin bad++; $display("FAIL cancel[%0d] result got=%h want=%h", i, res, er[i]); end
      total++;
      if (fl !== 3'b000) begin bad++; $display("FAIL cancel[%0d] flags got=%b want=000", i, fl); end
    end
  endtask

  task automatic test_back_to_back();
    logic        sg [4] = '{0, 0, 0, 0};
    logic [7:0]  ex [4] = '{127, 127, 127, 254};
    logic [27:0] mn [4] = '{28'h8000000, 28'h400000C, 28'h400000C, 28'h8000000};
    logic [1:0]  rm [4] = '{2'b00, 2'b00, 2'b01, 2'b11};
    logic [31:0] er [4] = '{32'h40000000, 32'h3F800002, 32'h3F800001, 32'h7F7FFFFF};
    int unsigned sent = 0, got = 0, cyc = 0, stall = 0;
    logic seen = 1'b0, held_v = 1'b0;
    logic [31:0] held = '0;
    @(negedge clk);
    while (got < 4 && cyc < 40) begin
      if (sent < 4) begin
        in_valid = 1'b1; in_sign = sg[sent]; in_exp = ex[sent]; in_mant = mn[sent]; in_rm = rm[sent];
      end else begin
        in_valid = 1'b0;
      end
      if (out_valid && !seen) begin seen = 1'b1; stall = 3; end
      out_ready = (stall == 0);
      #1;
      if (held_v) begin
        total++;
        if (out_valid !== 1'b1 || out_result !== held) begin
          bad++; $display("FAIL b2b hold got v=%b r=%h want v=1 r=%h", out_valid, out_result, held);
        end
      end
      if (stall != 0) begin
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL b2b full_in_ready got=%b want=0", in_ready); end
      end
      held_v = out_valid && !out_ready;
      held   = out_result;
      if (out_valid && out_ready) begin
        total++;
        if (out_result !== er[got]) begin
          bad++; $display("FAIL b2b result[%0d] got=%h want=%h", got, out_result, er[got]);
        end
        got++;
      end
      if (in_valid && in_ready) sent++;
      @(negedge clk);
      cyc++;
      if (stall != 0) stall--;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    total++;
    if (got != 4) begin bad++; $display("FAIL b2b count got=%0d want=4", got); end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b extra[%0d] got=%b want=0", i, out_valid); end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_inflight();
    logic [31:0] res; logic [2:0] fl; logic ok;
    @(negedge clk);
    out_ready = 1'b1;
    in_valid = 1'b1; in_sign = 1'b0; in_exp = 8'd127; in_mant = 28'h8000000; in_rm = 2'b00;
    @(negedge clk);
    in_mant = 28'h400000C;
    @(negedge clk);
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1) begin bad++; $display("FAIL inflight_pre got=%b want=1", out_valid); end
    #2 rst = 1'b1;
    #1;
    total++;
    if (out_valid !== 1'b0 || out_result !== 32'h0 ||
        {out_overflow, out_underflow, out_inexact} !== 3'b000 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL async_reset got v=%b r=%h f=%b rdy=%b want v=0 r=00000000 f=000 rdy=0",
               out_valid, out_result, {out_overflow, out_underflow, out_inexact}, in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL inflight_release_rdy got=%b want=0", in_ready); end
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL inflight_dropped got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready);
    end
    run_beat(1'b0, 8'd127, 28'h0200000, 2'b00, res, fl, ok);
    total++;
    if (!ok || res !== 32'h3D000000 || fl !== 3'b000) begin
      bad++; $display("FAIL post_reset_beat got ok=%b r=%h f=%b want ok=1 r=3d000000 f=000", ok, res, fl);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_rounding();
    test_overflow();
    test_cancel();
    test_back_to_back();
    test_reset_inflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
